// File: rtl/produto_acumulador.sv
// -----------------------------------------------------------------------------
// produto_acumulador
//
// Sits behind the combinational `produto` multiplier. It collects a frame of
// COUNT unsigned products and reduces them to one result. The reduction is a
// saturating sum (mode=0) or a running maximum (mode=1). The result is held
// until the consumer takes it.
//
// Ports:
//   clk        rising-edge clock
//   rst_n      asynchronous active-low reset
//   clear      synchronous frame abort; wins over accept and out_ready
//   in_valid   product sample valid
//   in_ready   stage can accept a sample (high in ACCUM)
//   in_prod    product value, unsigned, PROD_W bits
//   mode       0 = sum, 1 = max; latched on the first sample of a frame
//   out_valid  result available (high in HOLD)
//   out_ready  consumer accepts the result
//   out_data   frame result, unsigned, ACC_W bits
//   out_sat    the sum saturated during this frame; always 0 in max mode
// -----------------------------------------------------------------------------
module produto_acumulador #(
    parameter int PROD_W = 3,
    parameter int ACC_W  = 8,
    parameter int COUNT  = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              clear,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [PROD_W-1:0] in_prod,
    input  logic              mode,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [ACC_W-1:0]  out_data,
    output logic              out_sat
);

    localparam int CNT_W = (COUNT > 2) ? $clog2(COUNT) : 1;

    typedef enum logic {
        ACCUM = 1'b0,
        HOLD  = 1'b1
    } state_t;

    state_t             state;
    logic [ACC_W-1:0]   acc;
    logic [CNT_W-1:0]   cnt;
    logic               sat;
    logic               mode_q;

    logic [ACC_W-1:0]   prod_ext;
    logic [ACC_W-1:0]   sum_clamped;
    logic               sum_ovf;
    logic               first;
    logic               mode_eff;
    logic               last;
    logic [ACC_W-1:0]   acc_nxt;
    logic               sat_nxt;

    // Adds at ACC_W+1 bits and clamps to all-ones on carry-out.
    // Returns {overflow, clamped_value}.
    function automatic logic [ACC_W:0] sat_add(input logic [ACC_W-1:0] a,
                                               input logic [ACC_W-1:0] b);
        logic [ACC_W:0] s;
        s = {1'b0, a} + {1'b0, b};
        if (s[ACC_W])
            return {1'b1, {ACC_W{1'b1}}};
        return s;
    endfunction

    function automatic logic [ACC_W-1:0] max_val(input logic [ACC_W-1:0] a,
                                                 input logic [ACC_W-1:0] b);
        return (b > a) ? b : a;
    endfunction

    assign in_ready  = (state == ACCUM);
    assign out_valid = (state == HOLD);

    always_comb begin
        prod_ext = ACC_W'(in_prod);
        first    = (cnt == '0);
        last     = (cnt == CNT_W'(COUNT - 1));
        // The first sample of a frame uses the live mode input, since mode_q
        // only captures it on that same edge.
        mode_eff = first ? mode : mode_q;
        {sum_ovf, sum_clamped} = sat_add(acc, prod_ext);
        acc_nxt  = sum_clamped;
        sat_nxt  = sat | sum_ovf;
        if (mode_eff) begin
            acc_nxt = first ? prod_ext : max_val(acc, prod_ext);
            sat_nxt = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= ACCUM;
            acc      <= '0;
            cnt      <= '0;
            sat      <= 1'b0;
            mode_q   <= 1'b0;
            out_data <= '0;
            out_sat  <= 1'b0;
        end else if (clear) begin
            // Abort: drop the partial frame or any pending result. out_data
            // is left alone; it is only meaningful while out_valid is high.
            state <= ACCUM;
            acc   <= '0;
            cnt   <= '0;
            sat   <= 1'b0;
        end else begin
            case (state)
                ACCUM: begin
                    if (in_valid) begin
                        if (first)
                            mode_q <= mode;
                        acc <= acc_nxt;
                        sat <= sat_nxt;
                        if (last) begin
                            // cnt parks at COUNT-1 while the result is held.
                            state    <= HOLD;
                            out_data <= acc_nxt;
                            out_sat  <= sat_nxt;
                        end else begin
                            cnt <= cnt + CNT_W'(1);
                        end
                    end
                end
                HOLD: begin
                    if (out_ready) begin
                        state <= ACCUM;
                        acc   <= '0;
                        cnt   <= '0;
                        sat   <= 1'b0;
                    end
                end
            endcase
        end
    end

endmodule

// File: doc/produto_acumulador.md
Name: produto_acumulador

Overview:
- Sequential stage directly downstream of the combinational `produto` multiplier; consumes its product output C one sample at a time.
- Reduces a frame of COUNT products into one result, using a valid/ready handshake on both sides.
- The `mode` signal selects the reduction: 0 = saturating sum, 1 = running maximum.
- The result is held until the consumer accepts it.

Parameters:
- PROD_W, 3, width of incoming product (matches `produto` output C).
- ACC_W, 8, width of accumulated result; must be >= PROD_W.
- COUNT, 4, products per frame; range 2..255.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous active-low reset.
- clear  input  1  synchronous frame abort.
- in_valid  input  1  product sample valid.
- in_ready  output  1  stage can accept a sample.
- in_prod  input  PROD_W  product value, unsigned.
- mode  input  1  0 = sum, 1 = max; sampled on the first sample of each frame.
- out_valid  output  1  result available.
- out_ready  input  1  consumer accepts result.
- out_data  output  ACC_W  frame result, unsigned.
- out_sat  output  1  sum saturated during this frame; always 0 in max mode.

Behaviour:
- Reset (rst_n=0, asynchronous):
  - state=ACCUM, acc=0, cnt=0, mode_q=0.
  - in_ready=1, out_valid=0, out_data=0, out_sat=0.
  - Takes effect immediately, including mid-frame or mid-hold.
- States:
  - ACCUM: in_ready=1, out_valid=0.
  - HOLD: in_ready=0, out_valid=1.
- Accept: a sample is accepted when in_valid & in_ready at a rising edge. in_prod is ignored otherwise.
- Mode latch: on accept with cnt==0, mode_q <= mode. Later changes to mode within the frame are ignored.
- Sum mode (mode_q=0):
  - acc <= acc + zero-extended in_prod.
  - If the true sum exceeds 2^ACC_W-1, acc clamps to 2^ACC_W-1 and the sat flag sets.
  - The sat flag is sticky for the frame.
- Max mode (mode_q=1):
  - acc <= max(acc, in_prod).
  - The first sample of the frame loads directly, so acc=in_prod.
  - sat stays 0.
- Frame completion:
  - cnt increments on each accept.
  - The accept with cnt==COUNT-1 moves the state to HOLD.
  - out_data = final acc value, including that last sample; out_sat = final flag.
  - out_valid rises the cycle after the last accept (latency 1 clock).
- HOLD:
  - out_data and out_sat are stable while out_valid=1 and out_ready=0.
  - On out_ready=1 at an edge: state -> ACCUM, acc=0, cnt=0, sat=0, out_valid=0, and in_ready=1 from the next cycle.
  - No sample is accepted in the cycle the result is taken.
- out_data between frames: holds the last delivered value, or 0 after reset. It is valid only while out_valid=1.
- clear=1 at an edge, in any state:
  - acc=0, cnt=0, sat=0, state=ACCUM, out_valid=0.
  - Any pending result is discarded.
  - A sample presented that cycle is not accepted.
  - clear has priority over accept and over out_ready.
- Width rule: the intermediate sum is computed at ACC_W+1 bits before the clamp.
- Wrap-around: cnt never exceeds COUNT-1. acc never wraps.

Test Plan:
- Basic sum (defaults; mode=0; in_prod 4,4,4,4 back-to-back; out_ready=1):
  - out_valid=1 exactly one cycle after the 4th accept.
  - out_data=16, out_sat=0.
  - in_ready=0 during HOLD.
- Max mode (mode=1; in_prod 2,7,3,5):
  - out_data=7, out_sat=0.
  - Toggling mode to 0 after the first sample has no effect.
- Saturation (ACC_W=4; mode=0; in_prod 7,7,7,7):
  - acc clamps after the 3rd sample (7+7+7=21 > 15).
  - out_data=15, out_sat=1.
  - The next frame 1,1,1,1 gives out_data=4, out_sat=0.
- Backpressure and gaps:
  - in_valid toggles with idle gaps (samples 1,2,3,4); out_ready held 0 for 5 cycles after out_valid.
  - out_data=10 stays stable and in_ready stays 0.
  - Raising out_ready clears out_valid next edge; in_ready=1 on the following cycle.
- Abort (mode=0; samples 5,6; then clear=1 with in_valid=1, in_prod=7; then 1,1,1,1):
  - The 7 is not accepted.
  - The next result is out_data=4.
- Async reset mid-frame or in HOLD:
  - rst_n pulsed low between clock edges immediately forces out_valid=0, out_data=0, out_sat=0, in_ready=1.
  - After release, frame 3,3,3,3 yields 12.
